z80_bus_arbiter: RTL
====================

Z80_BUS_ARBITER -- requirements
Module: z80_bus_arbiter

Interface
REQ-001 Parameter TENURE_MAX, 16, maximum cycles a DMA master holds the bus before it is told to yield (range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 dma_req  input  2  per-master bus request, bit n = master n, level-sensitive.
REQ-005 dma_gnt  output  2  one-hot-or-zero grant to master n.
REQ-006 dma_yield  output  2  tenure-expired notice to the granted master.
REQ-007 BUSREQ_L  output  1  active-low bus request to the z80 core.
REQ-008 BUSACK_L  input  1  active-low bus acknowledge from the z80 core.
REQ-009 bus_owner  output  2  0 = CPU, 1 = master0, 2 = master1; selects addr/data/control mux.
REQ-010 dma_drive_en  output  1  high only while a DMA master may drive addr_bus, data_bus, MREQ_L, IORQ_L, RD_L, WR_L.

Function
REQ-011 The block SHALL implement states IDLE, REQ_BUS, GRANT and RELEASE.
REQ-012 IDLE: BUSREQ_L=1, dma_gnt=0; any dma_req bit set SHALL move to REQ_BUS next cycle.
REQ-013 REQ_BUS: BUSREQ_L=0; the winner SHALL be chosen and latched on entry using round-robin priority, i.e. the master not granted last wins a tie.
REQ-014 REQ_BUS: the block SHALL remain until BUSACK_L is sampled 0, then enter GRANT, asserting dma_gnt for the latched winner the following cycle.
REQ-015 If the latched winner drops dma_req while in REQ_BUS, the block SHALL still wait for BUSACK_L=0, then go to RELEASE without asserting any grant.
REQ-016 GRANT: BUSREQ_L=0; bus_owner SHALL equal winner+1; dma_drive_en SHALL be 1; the tenure counter SHALL start at 0 and increment each cycle.
REQ-017 When the counter reaches TENURE_MAX-1 and the other master's dma_req is 1, dma_yield for the granted master SHALL assert and hold until its dma_req drops.
REQ-018 When the counter reaches TENURE_MAX-1 and the other master is not requesting, the counter SHALL saturate and no yield SHALL be issued.
REQ-019 Granted dma_req=0 sampled in GRANT SHALL deassert dma_gnt, dma_yield and dma_drive_en on the next edge and enter RELEASE.
REQ-020 RELEASE: BUSREQ_L=1, bus_owner=0; the block SHALL remain until BUSACK_L is sampled 1, then enter IDLE.
REQ-021 The bus SHALL always return to the CPU between DMA tenures; there SHALL be no direct master-to-master handoff.
REQ-022 The round-robin pointer SHALL update only when a grant is actually issued.
REQ-023 Simultaneous requests from both masters in IDLE after reset SHALL grant master0 first.
REQ-024 dma_gnt SHALL never have more than one bit set, and dma_drive_en=1 SHALL imply BUSACK_L was 0 on the preceding edge.
REQ-025 BUSACK_L returning to 1 unexpectedly during GRANT SHALL drop the grant and dma_drive_en on the next edge and enter RELEASE.

Reset
REQ-026 On rst=1 the block SHALL asynchronously enter IDLE with BUSREQ_L=1, dma_gnt=0, dma_yield=0, bus_owner=0, dma_drive_en=0, counter=0, and the round-robin pointer favouring master0.
REQ-027 Reset asserted mid-GRANT SHALL release the bus immediately, with no RELEASE handshake.

Structure
REQ-028 Shared package z80_arb_pkg SHALL hold the state enum, the owner encoding (OWN_CPU, OWN_DMA0, OWN_DMA1) and the default TENURE_MAX.
REQ-029 The block SHALL contain one sub-module, z80_arb_rr: a two-requester round-robin picker with a last-grant input and a winner output.

Verification
REQ-030 Single request: dma_req=01 -> BUSREQ_L=0 next cycle; BUSACK_L=0 driven 3 cycles later -> dma_gnt=01, bus_owner=1, dma_drive_en=1; dma_req=00 -> BUSREQ_L=1, bus_owner=0.
REQ-031 Tie after reset: dma_req=11 -> master0 granted first; after master0 releases and the bus returns to the CPU, master1 is granted.
REQ-032 Tenure: TENURE_MAX=4, master0 granted, master1 requesting -> dma_yield[0]=1 on the 4th GRANT cycle; dma_yield stays 0 if master1 is idle.
REQ-033 Withdrawn request: dma_req drops during REQ_BUS -> no dma_gnt pulse; BUSREQ_L returns to 1 after BUSACK_L=0 is seen.
REQ-034 Reset mid-GRANT: rst pulse -> dma_gnt=00, BUSREQ_L=1 and dma_drive_en=0 within the same cycle, without waiting for a clock edge.
REQ-035 Assertion checks SHALL be active across all scenarios for one-hot grant and no drive without acknowledge.

Source files
------------

// File: rtl/z80_arb_pkg.sv
// Shared types and constants for the z80 DMA bus arbiter.
// Holds the state enum, the bus-owner encoding and the default tenure.
package z80_arb_pkg;

  localparam int unsigned TENURE_MAX_DEF = 16;
  localparam int unsigned CNT_W          = 8;
  localparam int unsigned OWN_W          = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ_BUS = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  localparam logic [OWN_W-1:0] OWN_CPU  = 2'd0;
  localparam logic [OWN_W-1:0] OWN_DMA0 = 2'd1;
  localparam logic [OWN_W-1:0] OWN_DMA1 = 2'd2;

  // One-hot grant mask for a master index.
  function automatic logic [1:0] mst_mask(input logic w);
    return w ? 2'b10 : 2'b01;
  endfunction

  // Mux-select encoding for a granted master.
  function automatic logic [OWN_W-1:0] owner_of(input logic w);
    return w ? OWN_DMA1 : OWN_DMA0;
  endfunction

endpackage

// File: rtl/z80_arb_rr.sv
// Two-requester round-robin picker: a tie goes to the master not granted last.
module z80_arb_rr (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_winner_c
);

  always_comb begin
    o_winner_c = ~i_last;
    if (i_req == 2'b01) begin
      o_winner_c = 1'b0;
    end else if (i_req == 2'b10) begin
      o_winner_c = 1'b1;
    end
  end

endmodule

// File: rtl/z80_bus_arbiter.sv
// Arbitrates two DMA masters for the z80 bus via BUSREQ_L/BUSACK_L, with
// round-robin fairness and a tenure limit; the CPU always regains the bus between tenures.
module z80_bus_arbiter
  import z80_arb_pkg::*;
#(
  parameter int unsigned TENURE_MAX = TENURE_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       dma_req,
  output logic [1:0]       dma_gnt,
  output logic [1:0]       dma_yield,
  output logic             BUSREQ_L,
  input  logic             BUSACK_L,
  output logic [OWN_W-1:0] bus_owner,
  output logic             dma_drive_en
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TENURE_MAX - 1);

  arb_state_e       r_state,   w_state_nxt;
  logic             r_winner,  w_winner_nxt;
  logic             r_last,    w_last_nxt;
  logic             r_dropped, w_dropped_nxt;
  logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
  logic [1:0]       r_gnt,     w_gnt_nxt;
  logic [1:0]       r_yield,   w_yield_nxt;
  logic             r_busreq_l, w_busreq_l_nxt;
  logic [OWN_W-1:0] r_owner,   w_owner_nxt;
  logic             r_drive,   w_drive_nxt;
  logic             w_rr_winner;

  z80_arb_rr u_rr (
    .i_req      (dma_req),
    .i_last     (r_last),
    .o_winner_c (w_rr_winner)
  );

  // State and registered outputs; reset hands the bus straight back to the CPU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_winner   <= 1'b0;
      r_last     <= 1'b1;
      r_dropped  <= 1'b0;
      r_cnt      <= '0;
      r_gnt      <= 2'b00;
      r_yield    <= 2'b00;
      r_busreq_l <= 1'b1;
      r_owner    <= OWN_CPU;
      r_drive    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_winner   <= w_winner_nxt;
      r_last     <= w_last_nxt;
      r_dropped  <= w_dropped_nxt;
      r_cnt      <= w_cnt_nxt;
      r_gnt      <= w_gnt_nxt;
      r_yield    <= w_yield_nxt;
      r_busreq_l <= w_busreq_l_nxt;
      r_owner    <= w_owner_nxt;
      r_drive    <= w_drive_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_winner_nxt   = r_winner;
    w_last_nxt     = r_last;
    w_dropped_nxt  = r_dropped;
    w_cnt_nxt      = r_cnt;
    w_gnt_nxt      = r_gnt;
    w_yield_nxt    = r_yield;
    w_busreq_l_nxt = r_busreq_l;
    w_owner_nxt    = r_owner;
    w_drive_nxt    = r_drive;

    case (r_state)
      ST_IDLE: begin
        if (|dma_req) begin
          w_state_nxt    = ST_REQ_BUS;
          w_winner_nxt   = w_rr_winner;
          w_dropped_nxt  = 1'b0;
          w_busreq_l_nxt = 1'b0;
        end
      end

      ST_REQ_BUS: begin
        // A winner that withdraws is remembered so the acknowledge is still honoured, then released.
        w_dropped_nxt = r_dropped | ~dma_req[r_winner];
        if (!BUSACK_L) begin
          if (w_dropped_nxt) begin
            w_state_nxt    = ST_RELEASE;
            w_busreq_l_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_GRANT;
            w_gnt_nxt   = mst_mask(r_winner);
            w_owner_nxt = owner_of(r_winner);
            w_drive_nxt = 1'b1;
            w_cnt_nxt   = '0;
            w_yield_nxt = 2'b00;
            w_last_nxt  = r_winner;
          end
        end
      end

      ST_GRANT: begin
        if (BUSACK_L || !dma_req[r_winner]) begin
          w_state_nxt    = ST_RELEASE;
          w_gnt_nxt      = 2'b00;
          w_yield_nxt    = 2'b00;
          w_drive_nxt    = 1'b0;
          w_owner_nxt    = OWN_CPU;
          w_busreq_l_nxt = 1'b1;
          w_cnt_nxt      = '0;
        end else begin
          if (r_cnt != CNT_LAST) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
          if ((w_cnt_nxt == CNT_LAST) && dma_req[~r_winner]) begin
            w_yield_nxt = mst_mask(r_winner);
          end
        end
      end

      ST_RELEASE: begin
        if (BUSACK_L) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign dma_gnt      = r_gnt;
  assign dma_yield    = r_yield;
  assign BUSREQ_L     = r_busreq_l;
  assign bus_owner    = r_owner;
  assign dma_drive_en = r_drive;

endmodule
